// File: rtl/mem_wait_ctrl.sv
// Core-to-memory access controller: one latched request, WAIT_CYCLES wait states, one-cycle ready pulse; read/write ready at request+WAIT_CYCLES+2.
// Requests are only taken in IDLE; define MEM_CTRL_WBUF_EN for a one-entry posted write buffer (writes ready next cycle, non-hit requests stall until drain).
module mem_wait_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_core_addr,
  input  logic [DATA_WIDTH-1:0] i_core_wdata,
  input  logic                  i_core_r_en,
  input  logic                  i_core_w_en,
  output logic [DATA_WIDTH-1:0] o_core_rdata,
  output logic                  o_core_ready,
  output logic                  o_conflict,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_w_en,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            count_q, count_d;
  logic                  op_wr_q, op_wr_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  conflict_q, conflict_d;
  logic                  ready;
  logic                  mem_w_en;
  logic                  req;

`ifdef MEM_CTRL_WBUF_EN
  // The posted write lives in addr_q/wdata_q; nothing else may touch them while it is pending.
  logic                  wb_vld_q, wb_vld_d;
`endif

  assign req = i_core_r_en | i_core_w_en;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    conflict_d = conflict_q;
    ready      = 1'b0;
    mem_w_en   = 1'b0;
`ifdef MEM_CTRL_WBUF_EN
    wb_vld_d   = wb_vld_q;
`endif

    case (state_q)
      S_IDLE: begin
`ifdef MEM_CTRL_WBUF_EN
        if (req) begin
          if (!wb_vld_q) begin
            addr_d  = i_core_addr;
            wdata_d = i_core_wdata;
            op_wr_d = i_core_w_en;
            count_d = WAIT_INIT;
            if (i_core_r_en && i_core_w_en) begin
              conflict_d = 1'b1;
            end
            if (i_core_w_en) begin
              wb_vld_d = 1'b1;
              state_d  = S_DONE;
            end else begin
              state_d  = S_WAIT;
            end
          end else if (!i_core_w_en && (i_core_addr == addr_q)) begin
            rdata_d = wdata_q;
            state_d = S_DONE;
          end
        end
`else
        if (req) begin
          addr_d  = i_core_addr;
          wdata_d = i_core_wdata;
          op_wr_d = i_core_w_en;
          count_d = WAIT_INIT;
          if (i_core_r_en && i_core_w_en) begin
            conflict_d = 1'b1;
          end
          state_d = S_WAIT;
        end
`endif
      end
      S_WAIT: begin
        if (count_q != 4'd0) begin
          count_d = count_q - 4'd1;
        end else begin
          if (op_wr_q) begin
            mem_w_en = 1'b1;
          end else begin
            rdata_d = i_mem_rdata;
          end
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef MEM_CTRL_WBUF_EN
    // Background drain; the FSM never enters WAIT while the buffer is full, so count is free.
    if (wb_vld_q) begin
      if (count_q != 4'd0) begin
        count_d = count_q - 4'd1;
      end else begin
        mem_w_en = 1'b1;
        wb_vld_d = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= 4'd0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      conflict_q <= conflict_d;
    end
  end

`ifdef MEM_CTRL_WBUF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_vld_q <= 1'b0;
    end else begin
      wb_vld_q <= wb_vld_d;
    end
  end
`endif

  assign o_core_rdata = rdata_q;
  assign o_core_ready = ready;
  assign o_conflict   = conflict_q;
  assign o_mem_addr   = addr_q;
  assign o_mem_wdata  = wdata_q;
  assign o_mem_w_en   = mem_w_en;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Directed bench for mem_wait_ctrl: DUT a uses WAIT_CYCLES=2 with a small RAM, DUT b uses WAIT_CYCLES=0 with a pattern ROM.
module tb_mem_wait_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int          checks = 0;
  int          failures = 0;

  logic [15:0] a_addr, a_wdata, a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_r_en, a_w_en, a_ready, a_conflict, a_mem_w_en;
  logic [15:0] b_addr, b_wdata, b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_r_en, b_w_en, b_ready, b_conflict, b_mem_w_en;

  mem_wait_ctrl #(.DATA_WIDTH(16), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .i_core_addr(a_addr), .i_core_wdata(a_wdata), .i_core_r_en(a_r_en), .i_core_w_en(a_w_en),
    .o_core_rdata(a_rdata), .o_core_ready(a_ready), .o_conflict(a_conflict),
    .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata), .o_mem_w_en(a_mem_w_en),
    .i_mem_rdata(a_mem_rdata)
  );

  mem_wait_ctrl #(.DATA_WIDTH(16), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .i_core_addr(b_addr), .i_core_wdata(b_wdata), .i_core_r_en(b_r_en), .i_core_w_en(b_w_en),
    .o_core_rdata(b_rdata), .o_core_ready(b_ready), .o_conflict(b_conflict),
    .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata), .o_mem_w_en(b_mem_w_en),
    .i_mem_rdata(b_mem_rdata)
  );

  logic [15:0] mem_a [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'h00;
  logic [15:0] pl_dat = 16'h0000;

  always @(posedge clk) begin
    if (pl_en) mem_a[pl_addr] <= pl_dat;
    else if (a_mem_w_en) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
  end
  assign a_mem_rdata = mem_a[a_mem_addr[7:0]];
  assign b_mem_rdata = b_mem_addr ^ 16'hA5A5;

  task automatic preload(input logic [7:0] addr, input logic [15:0] dat);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = addr; pl_dat = dat;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Presents one request for exactly the accepting edge, then scrambles the core inputs.
  task automatic issue_a(input logic r, input logic w, input logic [15:0] addr, input logic [15:0] dat);
    @(negedge clk);
    a_r_en = r; a_w_en = w; a_addr = addr; a_wdata = dat;
    @(posedge clk);
    #1;
    a_r_en = 1'b0; a_w_en = 1'b0; a_addr = 16'hFFFF; a_wdata = 16'h0000;
  endtask

  task automatic observe(input int n, output int wen_cyc, output int wen_cnt, output logic [15:0] wen_addr,
                         output logic [15:0] wen_dat, output int rdy_cyc, output int rdy_cnt);
    wen_cyc = -1; wen_cnt = 0; wen_addr = 16'h0; wen_dat = 16'h0; rdy_cyc = -1; rdy_cnt = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (a_mem_w_en) begin
        if (wen_cnt == 0) begin wen_cyc = k; wen_addr = a_mem_addr; wen_dat = a_mem_wdata; end
        wen_cnt++;
      end
      if (a_ready) begin
        if (rdy_cnt == 0) rdy_cyc = k;
        rdy_cnt++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; a_r_en = 0; a_w_en = 0; a_addr = 0; a_wdata = 0;
    b_r_en = 0; b_w_en = 0; b_addr = 0; b_wdata = 0;
    repeat (2) @(negedge clk);
    checks++; if (a_rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", a_rdata); end
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", a_ready); end
    checks++; if (a_conflict !== 1'b0) begin failures++; $display("FAIL reset_conflict got=%b exp=0", a_conflict); end
    checks++; if (a_mem_addr !== 16'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0000", a_mem_addr); end
    checks++; if (a_mem_wdata !== 16'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0000", a_mem_wdata); end
    checks++; if (a_mem_w_en !== 1'b0) begin failures++; $display("FAIL reset_mem_w_en got=%b exp=0", a_mem_w_en); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifndef MEM_CTRL_WBUF_EN
  task automatic test_write;
    int wc, wn, rc, rn; logic [15:0] wa, wd;
    issue_a(1'b0, 1'b1, 16'h0010, 16'h1234);
    observe(6, wc, wn, wa, wd, rc, rn);
    checks++; if (wn !== 1) begin failures++; $display("FAIL write_wen_pulses got=%0d exp=1", wn); end
    checks++; if (wc !== 3) begin failures++; $display("FAIL write_wen_cycle got=%0d exp=3", wc); end
    checks++; if (wa !== 16'h0010) begin failures++; $display("FAIL write_addr got=%h exp=0010", wa); end
    checks++; if (wd !== 16'h1234) begin failures++; $display("FAIL write_data got=%h exp=1234", wd); end
    checks++; if (rc !== 4 || rn !== 1) begin failures++; $display("FAIL write_ready got=cyc%0d/n%0d exp=cyc4/n1", rc, rn); end
    checks++; if (a_conflict !== 1'b0) begin failures++; $display("FAIL write_conflict got=%b exp=0", a_conflict); end
  endtask

  task automatic test_read;
    int wc, wn, rc, rn; logic [15:0] wa, wd;
    preload(8'h20, 16'hBEEF);
    issue_a(1'b1, 1'b0, 16'h0020, 16'h0000);
    observe(6, wc, wn, wa, wd, rc, rn);
    checks++; if (rc !== 4 || rn !== 1) begin failures++; $display("FAIL read_ready got=cyc%0d/n%0d exp=cyc4/n1", rc, rn); end
    checks++; if (wn !== 0) begin failures++; $display("FAIL read_no_wen got=%0d exp=0", wn); end
    checks++; if (a_rdata !== 16'hBEEF) begin failures++; $display("FAIL read_data got=%h exp=beef", a_rdata); end
    issue_a(1'b0, 1'b1, 16'h0040, 16'h1111);
    observe(6, wc, wn, wa, wd, rc, rn);
    checks++; if (a_rdata !== 16'hBEEF) begin failures++; $display("FAIL read_hold_after_write got=%h exp=beef", a_rdata); end
  endtask

  task automatic test_conflict;
    int wc, wn, rc, rn; logic [15:0] wa, wd;
    issue_a(1'b1, 1'b1, 16'h0050, 16'h7777);
    observe(6, wc, wn, wa, wd, rc, rn);
    checks++; if (wn !== 1 || wa !== 16'h0050 || wd !== 16'h7777) begin failures++; $display("FAIL conflict_write got=n%0d/%h/%h exp=n1/0050/7777", wn, wa, wd); end
    checks++; if (a_conflict !== 1'b1) begin failures++; $display("FAIL conflict_set got=%b exp=1", a_conflict); end
    issue_a(1'b1, 1'b0, 16'h0050, 16'h0000);
    observe(6, wc, wn, wa, wd, rc, rn);
    checks++; if (a_rdata !== 16'h7777) begin failures++; $display("FAIL conflict_readback got=%h exp=7777", a_rdata); end
    checks++; if (a_conflict !== 1'b1) begin failures++; $display("FAIL conflict_sticky got=%b exp=1", a_conflict); end
  endtask

  task automatic test_reset_mid;
    int wc, wn, rc, rn; logic [15:0] wa, wd;
    issue_a(1'b0, 1'b1, 16'h0060, 16'hDEAD);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({a_rdata, a_mem_addr, a_mem_wdata} !== 48'h0) begin failures++; $display("FAIL midrst_regs got=%h/%h/%h exp=0", a_rdata, a_mem_addr, a_mem_wdata); end
    checks++; if ({a_ready, a_conflict, a_mem_w_en} !== 3'b000) begin failures++; $display("FAIL midrst_flags got=%b exp=000", {a_ready, a_conflict, a_mem_w_en}); end
    @(negedge clk);
    rst_n = 1'b1;
    observe(6, wc, wn, wa, wd, rc, rn);
    checks++; if (wn !== 0 || rn !== 0) begin failures++; $display("FAIL midrst_aborted got=wen%0d/rdy%0d exp=0/0", wn, rn); end
    issue_a(1'b1, 1'b0, 16'h0020, 16'h0000);
    observe(6, wc, wn, wa, wd, rc, rn);
    checks++; if (rc !== 4 || a_rdata !== 16'hBEEF) begin failures++; $display("FAIL midrst_next got=cyc%0d/%h exp=cyc4/beef", rc, a_rdata); end
  endtask

  task automatic test_back_to_back;
    int rcyc [0:1]; logic [15:0] rdat [0:1]; int n = 0;
    rcyc[0] = -1; rcyc[1] = -1; rdat[0] = 0; rdat[1] = 0;
    @(negedge clk);
    b_addr = 16'h0001; b_r_en = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (b_ready) begin
        if (n < 2) begin rcyc[n] = k; rdat[n] = b_rdata; end
        n++;
        if (n == 1) b_addr = 16'h0002;
        else b_r_en = 1'b0;
      end
    end
    checks++; if (n !== 2) begin failures++; $display("FAIL b2b_ready_count got=%0d exp=2", n); end
    checks++; if (rcyc[0] !== 2 || rcyc[1] !== 5) begin failures++; $display("FAIL b2b_ready_cycles got=%0d,%0d exp=2,5", rcyc[0], rcyc[1]); end
    checks++; if (rdat[0] !== 16'hA5A4 || rdat[1] !== 16'hA5A7) begin failures++; $display("FAIL b2b_data got=%h,%h exp=a5a4,a5a7", rdat[0], rdat[1]); end
  endtask
`else
  task automatic test_wbuf;
    int wen_k, rdy_k, rdy_n;
    preload(8'h31, 16'h0F0F);
    @(negedge clk);
    a_w_en = 1'b1; a_addr = 16'h0030; a_wdata = 16'h5A5A;
    @(posedge clk);
    #1;
    a_w_en = 1'b0; a_wdata = 16'h0000;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL wbuf_write_ready got=%b exp=1", a_ready); end
    a_r_en = 1'b1; a_addr = 16'h0030;
    repeat (2) @(posedge clk);
    #1;
    a_r_en = 1'b0;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1 || a_rdata !== 16'h5A5A) begin failures++; $display("FAIL wbuf_hit got=%b/%h exp=1/5a5a", a_ready, a_rdata); end
    checks++; if (a_mem_w_en !== 1'b1 || a_mem_addr !== 16'h0030) begin failures++; $display("FAIL wbuf_drain got=%b/%h exp=1/0030", a_mem_w_en, a_mem_addr); end
    repeat (2) @(negedge clk);
    a_w_en = 1'b1; a_addr = 16'h0040; a_wdata = 16'hC3C3;
    @(posedge clk);
    #1;
    a_w_en = 1'b0;
    @(negedge clk);
    a_r_en = 1'b1; a_addr = 16'h0031;
    wen_k = -1; rdy_k = -1; rdy_n = 0;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (a_mem_w_en && wen_k < 0) wen_k = k;
      if (a_ready) begin
        if (rdy_n == 0) rdy_k = k;
        rdy_n++;
        a_r_en = 1'b0;
      end
    end
    checks++; if (wen_k !== 3) begin failures++; $display("FAIL wbuf_stall_drain got=%0d exp=3", wen_k); end
    checks++; if (rdy_k !== 8 || rdy_n !== 1) begin failures++; $display("FAIL wbuf_stall_ready got=cyc%0d/n%0d exp=cyc8/n1", rdy_k, rdy_n); end
    checks++; if (a_rdata !== 16'h0F0F) begin failures++; $display("FAIL wbuf_stall_data got=%h exp=0f0f", a_rdata); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef MEM_CTRL_WBUF_EN
    test_write();
    test_read();
    test_conflict();
    test_reset_mid();
    test_back_to_back();
`else
    test_wbuf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
